muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the execute stage, alongside the single-cycle ALU.
- It takes the same funct3 and operand buses that the ALU control path decodes. It runs when the control decoder flags an OP-type instruction with funct7 = 0000001.
- It holds the pipeline via busy while it computes, and returns one XLEN result with a single-cycle done pulse.
- Multiplies use radix-2 shift-add and divides use restoring division, one bit per cycle.

---
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide: radix-2 shift-add multiply, restoring divide.
// Latency: done pulses XLEN+1 cycles after acceptance; divide-by-zero/overflow pulse on the next cycle.
// Backpressure: busy stalls the pipeline; start is ignored in CALC, flush aborts with no done.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_f3;
    logic              neg;
    // acc_hi: product high half / partial remainder
    // acc_lo: multiplier being shifted out / dividend shifting into quotient
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [XLEN-1:0]   op_b;

    // acceptance-time decode of the operation and operand magnitudes
    logic              is_div_in;
    logic              a_sgn_in;
    logic              b_sgn_in;
    logic              a_neg_in;
    logic              b_neg_in;
    logic              neg_in;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   special_res;

    // Decode the incoming request: signedness, magnitudes, negate flag, special cases
    always_comb begin
        is_div_in   = funct3[2];
        a_sgn_in    = is_div_in ? ~funct3[0] : ((funct3 == 3'b001) || (funct3 == 3'b010));
        b_sgn_in    = is_div_in ? ~funct3[0] : (funct3 == 3'b001);
        a_neg_in    = a_sgn_in & srcA[XLEN-1];
        b_neg_in    = b_sgn_in & srcB[XLEN-1];
        a_mag       = a_neg_in ? (~srcA + 1'b1) : srcA;
        b_mag       = b_neg_in ? (~srcB + 1'b1) : srcB;
        // REM follows the dividend sign; everything else is the product/quotient sign
        neg_in      = (is_div_in && funct3[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
        div_zero    = is_div_in && (srcB == '0);
        div_ovf     = is_div_in && !funct3[0] &&
                      (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? srcA : '1;
        end else begin
            special_res = funct3[1] ? '0 : srcA;
        end
    end

    // one iteration of either datapath, plus the final signed result
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              q_bit;
    logic [XLEN-1:0]   step_hi;
    logic [XLEN-1:0]   step_lo;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   final_res;

    // Single shift-add / restore-subtract step and result formatting
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, op_b};
        q_bit     = ~div_diff[XLEN];
        if (op_f3[2]) begin
            step_hi = q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], q_bit};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
        prod      = {step_hi, step_lo};
        prod_s    = neg ? (~prod + 1'b1) : prod;
        final_res = '0;
        if (op_f3[2]) begin
            if (op_f3[1]) begin
                final_res = neg ? (~step_hi + 1'b1) : step_hi;
            end else begin
                final_res = neg ? (~step_lo + 1'b1) : step_lo;
            end
        end else if (op_f3 == 3'b000) begin
            final_res = prod_s[XLEN-1:0];
        end else begin
            final_res = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Control FSM and datapath registers; flush beats start, reset clears everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_f3  <= '0;
            neg    <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            op_b   <= '0;
            done   <= 1'b0;
            result <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN-1)) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= final_res;
                    end
                end
                default: begin
                    // IDLE, and DONE which may accept a back-to-back request
                    state <= IDLE;
                    if (start) begin
                        op_f3  <= funct3;
                        neg    <= neg_in;
                        acc_hi <= '0;
                        acc_lo <= is_div_in ? a_mag : b_mag;
                        op_b   <= is_div_in ? b_mag : a_mag;
                        cnt    <= '0;
                        if (div_zero || div_ovf) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= special_res;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, flush/reset/back-to-back, random ops.
// Reference model uses plain 64-bit and signed 32-bit arithmetic with RISC-V special-case rules.
// Inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_exp = 32'h0;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .srcA   (srcA),
        .srcB   (srcB),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        int          ia;
        int          ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op (called just after an edge), wait for done, check result, latency, busy span.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int          lat;
        int          bcnt;
        logic [31:0] exp;
        logic [31:0] res;
        exp    = model(f3, a, b);
        start  = 1'b1;
        funct3 = f3;
        srcA   = a;
        srcB   = b;
        @(posedge clk); #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        srcA   = $urandom;
        srcB   = $urandom;
        lat    = 1;
        bcnt   = 0;
        while (lat < 200) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) break;
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        check({tag, " result"}, res, exp);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat(f3, a, b)));
        check({tag, " busy cycles"}, 32'(bcnt), 32'(exp_lat(f3, a, b)));
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " done single pulse"}, 32'(done), 32'h0);
        check({tag, " busy after"}, 32'(busy), 32'h0);
        check({tag, " result held"}, result, exp);
        last_exp = exp;
        @(posedge clk); #1;
    endtask

    initial begin
        int          ndone;
        int          d1;
        int          d2;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; srcA = 32'h0; srcB = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset result", result, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // directed cases
        do_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD);
        do_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000);
        do_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2);
        do_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2);
        do_op("DIVU 100/7", 3'd5, 32'd100, 32'd7);
        do_op("REMU 100/7", 3'd7, 32'd100, 32'd7);
        do_op("DIVU 5/0", 3'd5, 32'd5, 32'd0);
        do_op("REM 5/0", 3'd6, 32'd5, 32'd0);
        do_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // flush mid-DIV with a simultaneous start that must be dropped
        start = 1'b1; funct3 = 3'd4; srcA = 32'd1000; srcB = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; start = 1'b1; funct3 = 3'd0; srcA = 32'd9; srcB = 32'd9;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check("flush busy", 32'(busy), 32'h0);
        check("flush done", 32'(done), 32'h0);
        check("flush result kept", result, last_exp);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("flush no done", 32'(ndone), 32'h0);
        check("flush start dropped", 32'(busy), 32'h0);
        @(posedge clk); #1;
        do_op("MUL 3*4 after flush", 3'd0, 32'd3, 32'd4);

        // back-to-back: start held through the DONE cycle
        start = 1'b1; funct3 = 3'd0; srcA = 32'd2; srcB = 32'd3;
        @(posedge clk); #1;
        srcA = 32'd5; srcB = 32'd5;
        d1 = 1;
        while (d1 < 200) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk); #1;
            d1++;
        end
        check("b2b first result", result, 32'd6);
        check("b2b first latency", 32'(d1), 32'd33);
        @(posedge clk); #1;
        start = 1'b0;
        d2 = d1 + 1;
        while (d2 < 400) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk); #1;
            d2++;
        end
        check("b2b second result", result, 32'd25);
        check("b2b spacing", 32'(d2 - d1), 32'd33);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // reset mid-CALC
        start = 1'b1; funct3 = 3'd1; srcA = 32'h1234_5678; srcB = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset busy", 32'(busy), 32'h0);
        check("midreset done", 32'(done), 32'h0);
        check("midreset result", result, 32'h0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midreset no done", 32'(ndone), 32'h0);
        @(posedge clk); #1;

        // randomized ops with bias toward special and small operands
        for (int i = 0; i < 40; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                3: begin ra = 32'($urandom_range(0, 1000)); rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 50)); end
                default: ;
            endcase
            do_op("random", rf3, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
